// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: the scan-out display read takes priority, and a CPU
// request/ack port uses the remaining RAM cycles.
module vram_arbiter #(
  parameter int FB_W     = 160,
  parameter int FB_H     = 120,
  parameter int SCALE_SH = 2
) (
  input  logic        clk_25mhz,
  input  logic        rst_n,
  input  logic        isDispRGB,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [14:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  output logic        ram_en,
  output logic        ram_we,
  output logic [14:0] ram_addr,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  rgb_out,
  output logic        rgb_valid
);

  localparam logic [14:0] FB_W_V   = 15'(FB_W);
  localparam logic [14:0] FB_WORDS = 15'(FB_W * FB_H);
  localparam logic [9:0]  SUB_MASK = 10'((1 << SCALE_SH) - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_t;

  // Constant multiply by the framebuffer width as a sum of shifted rows.
  function automatic logic [14:0] mul_fb_w(input logic [9:0] row);
    logic [14:0] acc;
    acc = 15'd0;
    for (int i = 0; i < 15; i++) begin
      acc = acc + (FB_W_V[4'(i)] ? (15'(row) << i) : 15'd0);
    end
    return acc;
  endfunction

  state_t      state_q, state_d;
  logic        cpu_ack_q, cpu_ack_d;
  logic [7:0]  cpu_rdata_q, cpu_rdata_d;
  logic [7:0]  rgb_out_q, rgb_out_d;
  logic        rgb_valid_q, rgb_valid_d;
  logic        disp_dly_q, disp_dly_d;
  logic        rd_vld_q, rd_vld_d;
  logic        rd_tag_q, rd_tag_d;

  logic        disp_slot_s;
  logic        cpu_go_s;
  logic        cpu_in_range_s;
  logic [9:0]  col_s;
  logic [9:0]  row_s;
  logic [14:0] disp_addr_s;
  logic        ram_en_s;
  logic        ram_we_s;
  logic [14:0] ram_addr_s;
  logic [7:0]  ram_wdata_s;

  assign col_s          = x >> SCALE_SH;
  assign row_s          = y >> SCALE_SH;
  assign disp_addr_s    = mul_fb_w(row_s) + 15'(col_s);
  assign disp_slot_s    = isDispRGB && ((x & SUB_MASK) == 10'd0);
  assign cpu_in_range_s = (cpu_addr < FB_WORDS);
  assign cpu_go_s       = (state_q == S_IDLE) && cpu_req && !disp_slot_s;

  // RAM port mux: display slot first, then an in-range CPU issue, else idle.
  always_comb begin
    ram_en_s    = 1'b0;
    ram_we_s    = 1'b0;
    ram_addr_s  = 15'd0;
    ram_wdata_s = 8'd0;
    if (disp_slot_s) begin
      ram_en_s   = 1'b1;
      ram_addr_s = disp_addr_s;
    end else if (cpu_go_s && cpu_in_range_s) begin
      ram_en_s    = 1'b1;
      ram_we_s    = cpu_we;
      ram_addr_s  = cpu_addr;
      ram_wdata_s = cpu_wdata;
    end else begin
      ram_en_s = 1'b0;
    end
  end

  // CPU access sequencing; data returned in WAIT belongs to the CPU only if tagged so.
  always_comb begin
    state_d     = state_q;
    cpu_ack_d   = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_go_s) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        state_d     = S_DONE;
        cpu_ack_d   = 1'b1;
        cpu_rdata_d = (rd_vld_q && !rd_tag_q) ? ram_rdata : 8'd0;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Read tag pipeline and display capture, blanked by the delayed active flag.
  always_comb begin
    rd_vld_d    = ram_en_s && !ram_we_s;
    rd_tag_d    = disp_slot_s;
    disp_dly_d  = isDispRGB;
    rgb_valid_d = disp_dly_q;
    if (!disp_dly_q) begin
      rgb_out_d = 8'd0;
    end else if (rd_vld_q && rd_tag_q) begin
      rgb_out_d = ram_rdata;
    end else begin
      rgb_out_d = rgb_out_q;
    end
  end

  // State and pipeline registers.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'd0;
      rgb_out_q   <= 8'd0;
      rgb_valid_q <= 1'b0;
      disp_dly_q  <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_tag_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      rgb_out_q   <= rgb_out_d;
      rgb_valid_q <= rgb_valid_d;
      disp_dly_q  <= disp_dly_d;
      rd_vld_q    <= rd_vld_d;
      rd_tag_q    <= rd_tag_d;
    end
  end

  // The RAM port is combinational, so reset gates it directly.
  assign ram_en    = rst_n & ram_en_s;
  assign ram_we    = rst_n & ram_we_s;
  assign ram_addr  = rst_n ? ram_addr_s : 15'd0;
  assign ram_wdata = rst_n ? ram_wdata_s : 8'd0;

  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign rgb_out   = rgb_out_q;
  assign rgb_valid = rgb_valid_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios plus a randomized scan/CPU mix
// checked against a framebuffer-level reference model.
module tb_vram_arbiter;

  logic        clk_25mhz = 1'b0;
  logic        rst_n;
  logic        isDispRGB;
  logic [9:0]  x, y;
  logic        cpu_req, cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rdata;
  logic        ram_en, ram_we;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'd0;
  logic [7:0]  rgb_out;
  logic        rgb_valid;

  logic [7:0]  mem      [0:32767];
  logic [7:0]  model_fb [0:32767];
  int checks = 0;
  int errors = 0;

  vram_arbiter #(.FB_W(160), .FB_H(120), .SCALE_SH(2)) dut (
    .clk_25mhz(clk_25mhz), .rst_n(rst_n), .isDispRGB(isDispRGB), .x(x), .y(y),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .rgb_out(rgb_out), .rgb_valid(rgb_valid)
  );

  always #20 clk_25mhz = ~clk_25mhz;

  // Synchronous single-port RAM with one-cycle read latency.
  always @(posedge clk_25mhz) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] = ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_blank();
    isDispRGB = 1'b0; x = 10'd0; y = 10'd0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; drive_blank();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd5; cpu_wdata = 8'h11;
    #1 rst_n = 1'b0;
    #4;
    checks++;
    if ({cpu_ack, cpu_rdata, rgb_out, rgb_valid, ram_en, ram_we, ram_addr, ram_wdata} !== 43'd0) begin
      errors++; $display("FAIL reset_outputs: ack=%b rdata=%h rgb=%h v=%b en=%b we=%b addr=%0d wd=%h expected all 0",
        cpu_ack, cpu_rdata, rgb_out, rgb_valid, ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk_25mhz); @(negedge clk_25mhz);
    rst_n = 1'b1; #2;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 15'd5, 8'h11}) begin
      errors++; $display("FAIL first_issue: en=%b we=%b addr=%0d wd=%h expected 1 1 5 11", ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk_25mhz); #2;
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL first_wait_ack: got %b expected 0", cpu_ack); end
    @(negedge clk_25mhz); #2;
    checks++;
    if (cpu_ack !== 1'b1) begin errors++; $display("FAIL first_ack: got %b expected 1", cpu_ack); end
    @(negedge clk_25mhz); cpu_req = 1'b0; #2;
    checks++;
    if (cpu_ack !== 1'b0) begin errors++; $display("FAIL first_ack_len: got %b expected 0", cpu_ack); end
  endtask

  task automatic test_display();
    logic [7:0] exp_rgb;
    mem[162] = 8'hA5; mem[163] = 8'h5A;
    @(negedge clk_25mhz); drive_blank();
    @(negedge clk_25mhz);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_25mhz);
      isDispRGB = 1'b1; x = 10'(8 + k); y = 10'd4; #2;
      if (k == 0 || k == 4) begin
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b0, 15'(162 + k / 4), 8'd0}) begin
          errors++; $display("FAIL disp_addr x=%0d: en=%b we=%b addr=%0d expected 1 0 %0d", x, ram_en, ram_we, ram_addr, 162 + k / 4);
        end
      end
      exp_rgb = (k < 2) ? 8'h00 : ((k < 6) ? 8'hA5 : 8'h5A);
      checks++;
      if ({rgb_valid, rgb_out} !== {(k >= 2), exp_rgb}) begin
        errors++; $display("FAIL disp_rgb k=%0d: valid=%b rgb=%h expected %b %h", k, rgb_valid, rgb_out, (k >= 2), exp_rgb);
      end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_25mhz); drive_blank(); #2;
    end
    checks++;
    if ({rgb_valid, rgb_out} !== 9'd0) begin
      errors++; $display("FAIL disp_blank: valid=%b rgb=%h expected 0 00", rgb_valid, rgb_out);
    end
  endtask

  task automatic test_cpu_write_read();
    @(negedge clk_25mhz); drive_blank();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd300; cpu_wdata = 8'h3C; #2;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 15'd300, 8'h3C}) begin
      errors++; $display("FAIL wr_issue: en=%b we=%b addr=%0d wd=%h expected 1 1 300 3c", ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk_25mhz); #2;
    checks++;
    if ({cpu_ack, ram_en} !== 2'b00) begin
      errors++; $display("FAIL wr_wait: ack=%b en=%b expected 0 0", cpu_ack, ram_en);
    end
    @(negedge clk_25mhz); #2;
    checks++;
    if ({cpu_ack, ram_en} !== 2'b10) begin
      errors++; $display("FAIL wr_ack: ack=%b en=%b expected 1 0", cpu_ack, ram_en);
    end
    @(negedge clk_25mhz); cpu_req = 1'b0; #2;
    @(negedge clk_25mhz);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd300; cpu_wdata = 8'h00; #2;
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 15'd300}) begin
      errors++; $display("FAIL rd_issue: en=%b we=%b addr=%0d expected 1 0 300", ram_en, ram_we, ram_addr);
    end
    @(negedge clk_25mhz);
    @(negedge clk_25mhz); #2;
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h3C}) begin
      errors++; $display("FAIL rd_data: ack=%b rdata=%h expected 1 3c", cpu_ack, cpu_rdata);
    end
    @(negedge clk_25mhz); cpu_req = 1'b0;
  endtask

  task automatic test_slot_collision();
    mem[323] = 8'h1F; mem[324] = 8'hC3; mem[325] = 8'h77; mem[500] = 8'h9E;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_25mhz);
      isDispRGB = 1'b1; x = 10'(12 + k); y = 10'd8;
      if (x == 10'd16) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd500; end
      if (x == 10'd20) cpu_req = 1'b0;
      #2;
      if (x == 10'd16 || x == 10'd17 || x == 10'd20) begin
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, (x == 10'd16) ? 15'd324 : ((x == 10'd17) ? 15'd500 : 15'd325)}) begin
          errors++; $display("FAIL coll_addr x=%0d: en=%b we=%b addr=%0d", x, ram_en, ram_we, ram_addr);
        end
      end
      if (x >= 10'd16 && x <= 10'd20) begin
        checks++;
        if (cpu_ack !== (x == 10'd19)) begin
          errors++; $display("FAIL coll_ack x=%0d: got %b expected %b", x, cpu_ack, (x == 10'd19));
        end
      end
      if (x == 10'd19) begin
        checks++;
        if (cpu_rdata !== 8'h9E) begin errors++; $display("FAIL coll_rdata: got %h expected 9e", cpu_rdata); end
      end
      if (x == 10'd18 || x == 10'd21) begin
        checks++;
        if (rgb_out !== 8'hC3) begin errors++; $display("FAIL coll_rgb x=%0d: got %h expected c3", x, rgb_out); end
      end
    end
    for (int k = 0; k < 3; k++) begin @(negedge clk_25mhz); drive_blank(); end
  endtask

  task automatic test_no_swap();
    mem[483] = 8'h21; mem[484] = 8'h42; mem[485] = 8'h63; mem[700] = 8'hE7;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_25mhz);
      isDispRGB = 1'b1; x = 10'(12 + k); y = 10'd12;
      if (x == 10'd15) begin cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd700; end
      if (x == 10'd18) cpu_req = 1'b0;
      #2;
      if (x == 10'd15 || x == 10'd16) begin
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, (x == 10'd15) ? 15'd700 : 15'd484}) begin
          errors++; $display("FAIL swap_addr x=%0d: en=%b we=%b addr=%0d", x, ram_en, ram_we, ram_addr);
        end
      end
      if (x == 10'd17) begin
        checks++;
        if ({cpu_ack, cpu_rdata, rgb_out} !== {1'b1, 8'hE7, 8'h21}) begin
          errors++; $display("FAIL swap_cpu: ack=%b rdata=%h rgb=%h expected 1 e7 21", cpu_ack, cpu_rdata, rgb_out);
        end
      end
      if (x == 10'd18 || x == 10'd19) begin
        checks++;
        if ({rgb_out, cpu_rdata} !== {8'h42, 8'hE7}) begin
          errors++; $display("FAIL swap_rgb x=%0d: rgb=%h rdata=%h expected 42 e7", x, rgb_out, cpu_rdata);
        end
      end
    end
    for (int k = 0; k < 3; k++) begin @(negedge clk_25mhz); drive_blank(); end
  endtask

  task automatic test_out_of_range();
    mem[19200] = 8'h77;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk_25mhz); drive_blank();
      cpu_req = 1'b1; cpu_we = (pass == 1); cpu_addr = 15'd19200; cpu_wdata = 8'hFF; #2;
      checks++;
      if ({ram_en, ram_we, ram_addr, ram_wdata} !== 25'd0) begin
        errors++; $display("FAIL oor_issue pass=%0d: en=%b we=%b addr=%0d wd=%h expected 0", pass, ram_en, ram_we, ram_addr, ram_wdata);
      end
      @(negedge clk_25mhz); #2;
      checks++;
      if ({cpu_ack, ram_en} !== 2'b00) begin errors++; $display("FAIL oor_wait pass=%0d: ack=%b en=%b", pass, cpu_ack, ram_en); end
      @(negedge clk_25mhz); #2;
      checks++;
      if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h00}) begin
        errors++; $display("FAIL oor_ack pass=%0d: ack=%b rdata=%h expected 1 00", pass, cpu_ack, cpu_rdata);
      end
      @(negedge clk_25mhz); cpu_req = 1'b0;
    end
    checks++;
    if (mem[19200] !== 8'h77) begin errors++; $display("FAIL oor_nowrite: mem=%h expected 77", mem[19200]); end
  endtask

  task automatic test_reset_mid();
    mem[1000] = 8'h5D; mem[1001] = 8'hB2;
    @(negedge clk_25mhz); drive_blank();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd1000;
    @(negedge clk_25mhz);
    @(negedge clk_25mhz); #2;
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5D}) begin
      errors++; $display("FAIL mid_pre: ack=%b rdata=%h expected 1 5d", cpu_ack, cpu_rdata);
    end
    @(negedge clk_25mhz); cpu_req = 1'b0;
    @(negedge clk_25mhz); cpu_req = 1'b1; cpu_addr = 15'd1001; #2;
    checks++;
    if ({ram_en, ram_addr} !== {1'b1, 15'd1001}) begin errors++; $display("FAIL mid_issue: en=%b addr=%0d", ram_en, ram_addr); end
    @(negedge clk_25mhz); cpu_req = 1'b0; #2;
    rst_n = 1'b0; #1;
    checks++;
    if ({cpu_ack, cpu_rdata, rgb_out, rgb_valid, ram_en, ram_we, ram_addr, ram_wdata} !== 43'd0) begin
      errors++; $display("FAIL mid_reset_outputs: ack=%b rdata=%h rgb=%h v=%b en=%b addr=%0d expected all 0",
        cpu_ack, cpu_rdata, rgb_out, rgb_valid, ram_en, ram_addr);
    end
    @(negedge clk_25mhz); @(negedge clk_25mhz);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #2;
      checks++;
      if (cpu_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack k=%0d: got %b expected 0", k, cpu_ack); end
      @(negedge clk_25mhz);
    end
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd1002; cpu_wdata = 8'h6A; #2;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 15'd1002, 8'h6A}) begin
      errors++; $display("FAIL mid_new_issue: en=%b we=%b addr=%0d wd=%h", ram_en, ram_we, ram_addr, ram_wdata);
    end
    @(negedge clk_25mhz);
    @(negedge clk_25mhz); #2;
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h00}) begin
      errors++; $display("FAIL mid_new_ack: ack=%b rdata=%h expected 1 00", cpu_ack, cpu_rdata);
    end
    @(negedge clk_25mhz); cpu_req = 1'b0;
    @(negedge clk_25mhz);
  endtask

  task automatic test_random();
    logic       hv [0:3];
    logic [7:0] hp [0:3];
    logic [7:0] slot_val, exp_rd;
    logic [14:0] a_r, pix;
    logic [9:0] xb, yb;
    logic       we_r, inr, act, slot, pend, issued, drop_next, exp_ack;
    logic [7:0] d_r;
    int         iss_t, pos;
    pend = 1'b0; issued = 1'b0; drop_next = 1'b0; iss_t = 0; slot_val = 8'd0;
    exp_rd = 8'd0; a_r = 15'd0; we_r = 1'b0; d_r = 8'd0; xb = 10'd0; yb = 10'd0;
    for (int i = 0; i < 32768; i++) model_fb[i] = mem[i];
    for (int t = 0; t < 1600; t++) begin
      @(negedge clk_25mhz);
      pos = t % 80;
      if (pos == 0) begin
        yb = 10'($urandom_range(0, 479));
        xb = 10'($urandom_range(0, 144) * 4);
      end
      act = (pos < 64);
      isDispRGB = act;
      x = act ? 10'(xb + 10'(pos)) : 10'($urandom_range(0, 639));
      y = act ? yb : 10'($urandom_range(0, 479));
      slot = act && (x % 4 == 0);
      if (drop_next) begin
        cpu_req = 1'b0; drop_next = 1'b0;
      end else if (!pend && $urandom_range(0, 3) == 0) begin
        pend = 1'b1; issued = 1'b0;
        we_r = 1'($urandom_range(0, 1));
        a_r = ($urandom_range(0, 9) == 0) ? 15'($urandom_range(19200, 32767)) : 15'($urandom_range(0, 19199));
        d_r = 8'($urandom);
        cpu_req = 1'b1; cpu_we = we_r; cpu_addr = a_r; cpu_wdata = d_r;
      end
      #2;
      if (slot) begin
        pix = 15'((y / 4) * 160 + (x / 4));
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b0, pix, 8'd0}) begin
          errors++; $display("FAIL rnd_disp t=%0d: en=%b we=%b addr=%0d expected 1 0 %0d", t, ram_en, ram_we, ram_addr, pix);
        end
        slot_val = model_fb[pix];
      end else if (pend && !issued) begin
        inr = (a_r < 15'd19200);
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== {inr, we_r & inr, inr ? a_r : 15'd0, (inr ? d_r : 8'd0)}) begin
          errors++; $display("FAIL rnd_cpu_issue t=%0d: en=%b we=%b addr=%0d wd=%h req addr=%0d we=%b", t, ram_en, ram_we, ram_addr, ram_wdata, a_r, we_r);
        end
        exp_rd = (!we_r && inr) ? model_fb[a_r] : 8'd0;
        if (we_r && inr) model_fb[a_r] = d_r;
        issued = 1'b1; iss_t = t;
      end else begin
        checks++;
        if ({ram_en, ram_we, ram_addr, ram_wdata} !== 25'd0) begin
          errors++; $display("FAIL rnd_idle t=%0d: en=%b we=%b addr=%0d wd=%h expected 0", t, ram_en, ram_we, ram_addr, ram_wdata);
        end
      end
      if (t >= 2) begin
        checks++;
        if ({rgb_valid, rgb_out} !== {hv[(t - 2) % 4], hp[(t - 2) % 4]}) begin
          errors++; $display("FAIL rnd_rgb t=%0d: valid=%b rgb=%h expected %b %h", t, rgb_valid, rgb_out, hv[(t - 2) % 4], hp[(t - 2) % 4]);
        end
      end
      hv[t % 4] = act;
      hp[t % 4] = act ? slot_val : 8'd0;
      exp_ack = pend && issued && (t == iss_t + 2);
      checks++;
      if (cpu_ack !== exp_ack) begin
        errors++; $display("FAIL rnd_ack t=%0d: got %b expected %b", t, cpu_ack, exp_ack);
      end
      if (exp_ack) begin
        checks++;
        if (cpu_rdata !== exp_rd) begin
          errors++; $display("FAIL rnd_rdata t=%0d addr=%0d: got %h expected %h", t, a_r, cpu_rdata, exp_rd);
        end
        pend = 1'b0; drop_next = 1'b1;
      end
    end
    @(negedge clk_25mhz); cpu_req = 1'b0; drive_blank();
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
    test_reset();
    test_display();
    test_cpu_write_read();
    test_slot_collision();
    test_no_swap();
    test_out_of_range();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 The block SHALL have parameter FB_W, default 160, meaning framebuffer width in words (one 8-bit pixel per word).
REQ-002 The block SHALL have parameter FB_H, default 120, meaning framebuffer height in words.
REQ-003 The block SHALL have parameter SCALE_SH, default 2, meaning the log2 of the screen-to-framebuffer downscale (4x4 screen pixels per word).
REQ-004 The block SHALL have the port clk_25mhz  in  1  pixel clock; the only clock in the block.
REQ-005 The block SHALL have the port rst_n  in  1  reset, asynchronous and active-low.
REQ-006 The block SHALL have the port isDispRGB  in  1  high while the timing generator is inside the active area.
REQ-007 The block SHALL have the ports x, y  in  10 each  active-area pixel coordinates (x 0..639, y 0..479).
REQ-008 The block SHALL have the ports cpu_req  in  1  and cpu_we  in  1  meaning CPU access request (level, held until ack) and write-not-read.
REQ-009 The block SHALL have the ports cpu_addr  in  15  and cpu_wdata  in  8  meaning CPU word address and write data.
REQ-010 The block SHALL have the ports cpu_ack  out  1  and cpu_rdata  out  8  meaning one-cycle completion pulse and read data valid with ack.
REQ-011 The block SHALL have the ports ram_en, ram_we  out  1 each; ram_addr  out  15; ram_wdata  out  8; ram_rdata  in  8: single-port synchronous VRAM with one-cycle read latency.
REQ-012 The block SHALL have the ports rgb_out  out  8  and rgb_valid  out  1  meaning pixel colour to the DAC and the active-area flag aligned to it.

Function
REQ-013 The block SHALL treat a cycle with isDispRGB=1 and x[1:0]=0 as a display slot.
REQ-014 In a display slot, the block SHALL drive ram_en=1, ram_we=0, ram_addr=(y>>2)*FB_W+(x>>2), computed combinationally in the same cycle.
REQ-015 The block SHALL register the RAM data of a display read at the end of the next cycle into rgb_out, giving rgb_out for coordinate (x,y) two cycles after (x,y) is presented.
REQ-016 The block SHALL hold rgb_out until the next display capture.
REQ-017 The block SHALL drive rgb_valid as isDispRGB delayed two cycles, and SHALL force rgb_out to 0 whenever the two-cycle-delayed isDispRGB is 0.
REQ-018 The block SHALL implement the CPU FSM states IDLE, WAIT and DONE.
REQ-019 IDLE->WAIT SHALL occur when cpu_req=1 in a cycle that is not a display slot; in that cycle the block SHALL drive ram_en=1, ram_we=cpu_we, ram_addr=cpu_addr and ram_wdata=cpu_wdata.
REQ-020 WAIT->DONE SHALL occur unconditionally, and in WAIT the block SHALL capture ram_rdata into cpu_rdata (read) or capture 0 (write).
REQ-021 In DONE the block SHALL assert cpu_ack=1 for exactly one cycle, then transition DONE->IDLE.
REQ-022 The block SHALL NOT issue a new CPU access in WAIT or DONE; the earliest next issue is the cycle after ack.
REQ-023 The requester SHALL drop cpu_req in the cycle following ack, or that request is treated as a new request.
REQ-024 Display slots SHALL always win over CPU requests.
REQ-025 A display slot MAY issue while the CPU FSM is in WAIT or DONE, because the RAM accepts one access per cycle.
REQ-026 The block SHALL associate each captured read with its issuing requester through a one-bit tag pipeline, so captures are never swapped.
REQ-027 When cpu_addr >= FB_W*FB_H, the block SHALL hold ram_en=0, SHALL still follow the IDLE->WAIT->DONE sequence, SHALL return cpu_rdata=0, and SHALL pulse cpu_ack.
REQ-028 The block SHALL compute the display address with a 15-bit result, as shifts and adds with no multiplier: (y>>2)<<7 + (y>>2)<<5 when FB_W=160.
REQ-029 When no access is issued, the block SHALL drive ram_en=0, ram_we=0, and ram_addr and ram_wdata to 0.
REQ-030 Outside the active area, every non-busy cycle SHALL be available to the CPU, with a CPU access issued whenever cpu_req=1 and the FSM is in IDLE.

Reset
REQ-031 On rst_n=0, the block SHALL immediately, asynchronously, set the FSM to IDLE and clear cpu_ack, cpu_rdata, rgb_out, rgb_valid, the delay and tag pipelines, and all ram_* outputs.
REQ-032 Reset asserted mid-operation SHALL abort the in-flight CPU access with no ack; a write already issued to RAM MAY have completed.
REQ-033 After rst_n rises, the first CPU issue SHALL be possible on the first clock edge.

Verification
REQ-034 The bench SHALL apply isDispRGB=1, x=8, y=4, with RAM word 162 = 8'hA5 -> ram_addr=162 in that cycle; rgb_out=8'hA5 and rgb_valid=1 two cycles later; rgb_out held for 4 cycles.
REQ-035 The bench SHALL apply CPU write addr 300, data 8'h3C while blanked -> ram_we=1, ram_addr=300 in the issue cycle; cpu_ack 2 cycles later; a subsequent read of addr 300 returns 8'h3C with ack.
REQ-036 The bench SHALL raise cpu_req in a display slot (x=16) -> the CPU access is issued at x=17, ack at x=19; the display read at x=16 is unaffected.
REQ-037 The bench SHALL issue a CPU read at x=15 with the next display slot at x=16 -> cpu_rdata holds the CPU word, and the rgb_out sequence shows the display word; no swap occurs.
REQ-038 The bench SHALL write to cpu_addr=19200 -> ram_en stays 0, cpu_ack pulses after 2 cycles, cpu_rdata=0.
REQ-039 The bench SHALL assert rst_n=0 while the CPU FSM is in WAIT -> no cpu_ack ever pulses for that request, all outputs are 0 immediately, and a new request issues normally after release.
